// File: rtl/serial_mem_pkg.sv
// Shared encodings for the serial-to-memory bridge: FSM states and the
// ASCII command/response characters of the byte protocol.
package serial_mem_pkg;

  typedef enum logic [3:0] {
    ST_WAIT    = 4'd0,
    ST_CMD     = 4'd1,
    ST_LEN     = 4'd2,
    ST_ADDR    = 4'd3,
    ST_RD_REQ  = 4'd4,
    ST_RD_WAIT = 4'd5,
    ST_RD_SEND = 4'd6,
    ST_WR_DATA = 4'd7,
    ST_WR_WAIT = 4'd8,
    ST_RESP    = 4'd9
  } state_t;

  localparam logic [7:0] CH_START    = 8'h21; // '!'
  localparam logic [7:0] CMD_READ    = 8'h52; // 'R'
  localparam logic [7:0] CMD_WRITE   = 8'h57; // 'W'
  localparam logic [7:0] CMD_VERSION = 8'h56; // 'V'
  localparam logic [7:0] CMD_PING    = 8'h50; // 'P'

  localparam logic [7:0] RSP_READ    = 8'h72; // 'r'
  localparam logic [7:0] RSP_WRITE   = 8'h77; // 'w'
  localparam logic [7:0] RSP_OVERRUN = 8'h25; // '%'
  localparam logic [7:0] RSP_UNKNOWN = 8'h3F; // '?'
  localparam logic [7:0] RSP_PING    = 8'h70; // 'p'
  localparam logic [7:0] RSP_RESYNC  = 8'h21; // '!'

endpackage

// File: rtl/uart_tx_pacer.sv
// One-byte transmit holding register: accepts a byte when empty and strobes it
// out once the UART is ready, never on two consecutive cycles.
module uart_tx_pacer (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  logic [7:0] i_data,
  output logic       o_free,
  input  logic       i_ready,
  output logic [7:0] o_txd,
  output logic       o_strobe
);

  logic       r_pending;
  logic [7:0] r_data;
  logic       r_strobe;

  // Free only when nothing is held and no strobe is on the wire, so the data
  // register cannot change underneath an asserted strobe.
  assign o_free   = !r_pending && !r_strobe;
  assign o_txd    = r_data;
  assign o_strobe = r_strobe;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= 1'b0;
      r_data    <= 8'h00;
      r_strobe  <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (i_push && o_free) begin
        r_data    <= i_data;
        r_pending <= 1'b1;
      end else if (r_pending && i_ready && !r_strobe) begin
        r_strobe  <= 1'b1;
        r_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_mem_bridge.sv
// UART byte-protocol front end for a word-wide memory controller: parses
// '!'-framed read/write/version/ping commands and moves bytes to/from memory.
module serial_mem_bridge
  import serial_mem_pkg::*;
#(
  parameter int         ADDR_BITS  = 32,
  parameter int         LEN_BITS   = 24,
  parameter int         DATA_BYTES = 2,
  parameter logic [7:0] VERSION    = 8'h32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              uart_rxd,
  input  logic                    uart_rxd_strobe,
  output logic [7:0]              uart_txd,
  output logic                    uart_txd_strobe,
  input  logic                    uart_txd_ready,
  output logic [ADDR_BITS-1:0]    sd_addr,
  output logic [8*DATA_BYTES-1:0] sd_wr_data,
  output logic [DATA_BYTES-1:0]   sd_wr_mask,
  input  logic [8*DATA_BYTES-1:0] sd_rd_data,
  input  logic                    sd_ack,
  input  logic                    sd_idle,
  output logic                    sd_we,
  output logic                    sd_enable,
  output logic                    busy
);

  localparam int WORD_W     = 8 * DATA_BYTES;
  localparam int LANE_W     = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int LEN_BYTES  = LEN_BITS / 8;
  localparam int ADDR_BYTES = ADDR_BITS / 8;

  state_t                r_state, w_state_nxt;
  logic [2:0]            r_cnt;
  logic [LEN_BITS-1:0]   r_len;
  logic [ADDR_BITS-1:0]  r_addr;
  logic                  r_is_wr;
  logic                  r_overrun;
  logic [WORD_W-1:0]     r_word;
  logic                  r_sd_enable;
  logic                  r_sd_we;
  logic [WORD_W-1:0]     r_wr_data;
  logic [DATA_BYTES-1:0] r_wr_mask;
  logic [7:0]            r_resp0, r_resp1;
  logic [1:0]            r_resp_n;

  logic                  w_tx_push;
  logic [7:0]            w_tx_data;
  logic                  w_tx_free;
  logic [LANE_W-1:0]     w_lane;
  logic [ADDR_BITS-1:0]  w_addr_inc;
  logic                  w_cross;
  logic                  w_last;
  logic [7:0]            w_rd_byte;
  logic                  w_rx_ignored;
  logic                  w_ovr_nxt;

  function automatic logic [LANE_W-1:0] lane_of(input logic [ADDR_BITS-1:0] a);
    if (DATA_BYTES > 1) return a[LANE_W-1:0];
    else                return '0;
  endfunction

  function automatic logic [7:0] completion(input logic ovr, input logic wr);
    if (ovr)     return RSP_OVERRUN;
    else if (wr) return RSP_WRITE;
    else         return RSP_READ;
  endfunction

  assign w_lane     = lane_of(r_addr);
  assign w_addr_inc = r_addr + ADDR_BITS'(1);
  assign w_cross    = (lane_of(w_addr_inc) == '0);
  assign w_last     = (r_len == LEN_BITS'(1));
  assign w_rd_byte  = r_word[8*w_lane +: 8];

  // Bytes arriving while the bridge is driving memory reads or output are
  // discarded; the flag turns the completion byte into '%'.
  assign w_rx_ignored = uart_rxd_strobe &&
                        (r_state == ST_RD_REQ || r_state == ST_RD_WAIT ||
                         r_state == ST_RD_SEND || r_state == ST_WR_WAIT ||
                         r_state == ST_RESP);
  assign w_ovr_nxt = r_overrun || w_rx_ignored;

  assign sd_addr    = r_addr;
  assign sd_wr_data = r_wr_data;
  assign sd_wr_mask = r_wr_mask;
  assign sd_enable  = r_sd_enable;
  assign sd_we      = r_sd_we;
  assign busy       = (r_state != ST_WAIT);

  uart_tx_pacer u_tx_pacer (
    .clk      (clk),
    .reset    (reset),
    .i_push   (w_tx_push),
    .i_data   (w_tx_data),
    .o_free   (w_tx_free),
    .i_ready  (uart_txd_ready),
    .o_txd    (uart_txd),
    .o_strobe (uart_txd_strobe)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_WAIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tx_push   = 1'b0;
    w_tx_data   = 8'h00;
    case (r_state)
      ST_WAIT: begin
        if (uart_rxd_strobe) begin
          if (uart_rxd == CH_START) begin
            w_state_nxt = ST_CMD;
          end else begin
            w_tx_push = w_tx_free;
            w_tx_data = RSP_RESYNC;
          end
        end
      end
      ST_CMD: begin
        if (uart_rxd_strobe) begin
          if (uart_rxd == CMD_READ || uart_rxd == CMD_WRITE) w_state_nxt = ST_LEN;
          else                                               w_state_nxt = ST_RESP;
        end
      end
      ST_LEN: begin
        if (uart_rxd_strobe && r_cnt == 3'(LEN_BYTES - 1)) w_state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        if (uart_rxd_strobe && r_cnt == 3'(ADDR_BYTES - 1)) begin
          if (r_len == '0)  w_state_nxt = ST_RESP;
          else if (r_is_wr) w_state_nxt = ST_WR_DATA;
          else              w_state_nxt = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (sd_idle) w_state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (sd_ack) w_state_nxt = ST_RD_SEND;
      end
      ST_RD_SEND: begin
        if (w_tx_free) begin
          w_tx_push = 1'b1;
          w_tx_data = w_rd_byte;
          if (w_last)       w_state_nxt = ST_RESP;
          else if (w_cross) w_state_nxt = ST_RD_REQ;
        end
      end
      ST_WR_DATA: begin
        if (uart_rxd_strobe) w_state_nxt = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (r_sd_enable && sd_ack) w_state_nxt = w_last ? ST_RESP : ST_WR_DATA;
      end
      ST_RESP: begin
        if (w_tx_free) begin
          w_tx_push = 1'b1;
          w_tx_data = r_resp0;
          if (r_resp_n <= 2'd1) w_state_nxt = ST_WAIT;
        end
      end
      default: w_state_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_len       <= '0;
      r_addr      <= '0;
      r_is_wr     <= 1'b0;
      r_overrun   <= 1'b0;
      r_word      <= '0;
      r_sd_enable <= 1'b0;
      r_sd_we     <= 1'b0;
      r_wr_data   <= '0;
      r_wr_mask   <= '0;
      r_resp0     <= 8'h00;
      r_resp1     <= 8'h00;
      r_resp_n    <= 2'd0;
    end else begin
      if (w_rx_ignored) r_overrun <= 1'b1;
      case (r_state)
        ST_CMD: begin
          if (uart_rxd_strobe) begin
            r_overrun <= 1'b0;
            r_cnt     <= '0;
            r_len     <= '0;
            r_is_wr   <= (uart_rxd == CMD_WRITE);
            r_resp_n  <= 2'd1;
            case (uart_rxd)
              CMD_VERSION: begin
                r_resp0  <= VERSION;
                r_resp1  <= 8'(DATA_BYTES);
                r_resp_n <= 2'd2;
              end
              CMD_PING:            r_resp0 <= RSP_PING;
              CMD_READ, CMD_WRITE: r_resp0 <= r_resp0;
              default:             r_resp0 <= RSP_UNKNOWN;
            endcase
          end
        end
        ST_LEN: begin
          if (uart_rxd_strobe) begin
            r_len <= (r_len << 8) | LEN_BITS'(uart_rxd);
            r_cnt <= (r_cnt == 3'(LEN_BYTES - 1)) ? 3'd0 : r_cnt + 3'd1;
          end
        end
        ST_ADDR: begin
          if (uart_rxd_strobe) begin
            r_addr <= (r_addr << 8) | ADDR_BITS'(uart_rxd);
            r_cnt  <= r_cnt + 3'd1;
            if (r_cnt == 3'(ADDR_BYTES - 1) && r_len == '0) begin
              r_resp0  <= completion(r_overrun, r_is_wr);
              r_resp_n <= 2'd1;
            end
          end
        end
        ST_RD_REQ: begin
          if (sd_idle) begin
            r_sd_enable <= 1'b1;
            r_sd_we     <= 1'b0;
          end
        end
        ST_RD_WAIT: begin
          if (sd_ack) begin
            r_word      <= sd_rd_data;
            r_sd_enable <= 1'b0;
          end
        end
        ST_RD_SEND: begin
          if (w_tx_free) begin
            r_addr <= w_addr_inc;
            r_len  <= r_len - LEN_BITS'(1);
            if (w_last) begin
              r_resp0  <= completion(w_ovr_nxt, 1'b0);
              r_resp_n <= 2'd1;
            end
          end
        end
        ST_WR_DATA: begin
          if (uart_rxd_strobe) begin
            r_wr_data <= WORD_W'(uart_rxd) << (8 * w_lane);
            r_wr_mask <= DATA_BYTES'(1) << w_lane;
          end
        end
        ST_WR_WAIT: begin
          if (!r_sd_enable) begin
            if (sd_idle) begin
              r_sd_enable <= 1'b1;
              r_sd_we     <= 1'b1;
            end
          end else if (sd_ack) begin
            r_sd_enable <= 1'b0;
            r_sd_we     <= 1'b0;
            r_addr      <= w_addr_inc;
            r_len       <= r_len - LEN_BITS'(1);
            if (w_last) begin
              r_resp0  <= completion(w_ovr_nxt, 1'b1);
              r_resp_n <= 2'd1;
            end
          end
        end
        ST_RESP: begin
          if (w_tx_free) begin
            r_resp0  <= r_resp1;
            r_resp_n <= r_resp_n - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mem_bridge.sv
// Directed bench for serial_mem_bridge with a delayed-ack word memory model.
module tb_serial_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  uart_rxd;
  logic        uart_rxd_strobe;
  logic [7:0]  uart_txd;
  logic        uart_txd_strobe;
  logic        uart_txd_ready;
  logic [31:0] sd_addr;
  logic [15:0] sd_wr_data;
  logic [1:0]  sd_wr_mask;
  logic [15:0] sd_rd_data;
  logic        sd_ack;
  logic        sd_idle;
  logic        sd_we;
  logic        sd_enable;
  logic        busy;

  logic        mdl_ack;
  logic        tb_ack;
  int          ack_delay;
  int          mdl_cnt;
  int          rd_count;
  int          en_rises;
  logic        en_prev;
  logic [15:0] mem [0:127];
  logic [7:0]  tx_q [$];
  logic [31:0] wr_addr_q [$];
  logic [1:0]  wr_mask_q [$];
  logic [15:0] wr_data_q [$];

  int n_checks = 0;
  int n_errors = 0;

  assign sd_ack = mdl_ack | tb_ack;

  always #5 clk = ~clk;

  serial_mem_bridge dut (
    .clk             (clk),
    .reset           (reset),
    .uart_rxd        (uart_rxd),
    .uart_rxd_strobe (uart_rxd_strobe),
    .uart_txd        (uart_txd),
    .uart_txd_strobe (uart_txd_strobe),
    .uart_txd_ready  (uart_txd_ready),
    .sd_addr         (sd_addr),
    .sd_wr_data      (sd_wr_data),
    .sd_wr_mask      (sd_wr_mask),
    .sd_rd_data      (sd_rd_data),
    .sd_ack          (sd_ack),
    .sd_idle         (sd_idle),
    .sd_we           (sd_we),
    .sd_enable       (sd_enable),
    .busy            (busy)
  );

  // Memory model: acknowledges a held request after ack_delay cycles.
  always @(posedge clk) begin
    mdl_ack <= 1'b0;
    en_prev <= sd_enable;
    if (sd_enable && !en_prev) en_rises <= en_rises + 1;
    if (uart_txd_strobe) tx_q.push_back(uart_txd);
    if (sd_enable && !mdl_ack) begin
      if (mdl_cnt >= ack_delay - 1) begin
        mdl_ack <= 1'b1;
        mdl_cnt <= 0;
        if (sd_we) begin
          wr_addr_q.push_back(sd_addr);
          wr_mask_q.push_back(sd_wr_mask);
          wr_data_q.push_back(sd_wr_data);
          if (sd_wr_mask[0]) mem[sd_addr[7:1]][7:0]  <= sd_wr_data[7:0];
          if (sd_wr_mask[1]) mem[sd_addr[7:1]][15:8] <= sd_wr_data[15:8];
        end else begin
          sd_rd_data <= mem[sd_addr[7:1]];
          rd_count   <= rd_count + 1;
        end
      end else begin
        mdl_cnt <= mdl_cnt + 1;
      end
    end else if (!sd_enable) begin
      mdl_cnt <= 0;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    uart_rxd        = b;
    uart_rxd_strobe = 1'b1;
    @(negedge clk);
    uart_rxd_strobe = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [23:0] len, input logic [31:0] addr);
    send_byte(8'h21);
    send_byte(cmd);
    for (int i = 2; i >= 0; i--) send_byte(len[8*i +: 8]);
    for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
  endtask

  task automatic wait_tx(input int n, input int budget);
    for (int i = 0; i < budget && tx_q.size() < n; i++) @(negedge clk);
    check_eq("tx_count", tx_q.size(), n);
  endtask

  task automatic wait_wr(input int n, input int budget);
    for (int i = 0; i < budget && wr_addr_q.size() < n; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic get_tx(output logic [7:0] b);
    if (tx_q.size() > 0) b = tx_q.pop_front();
    else                 b = 8'hxx;
  endtask

  task automatic check_wr(input string tag, input logic [31:0] a, input logic [1:0] m, input logic [15:0] d);
    logic [31:0] oa;
    logic [1:0]  om;
    logic [15:0] od;
    if (wr_addr_q.size() > 0) begin
      oa = wr_addr_q.pop_front();
      om = wr_mask_q.pop_front();
      od = wr_data_q.pop_front();
    end else begin
      oa = 'x; om = 'x; od = 'x;
    end
    check_eq({tag, "_addr"}, oa, a);
    check_eq({tag, "_mask"}, om, m);
    check_eq({tag, "_data"}, od, d);
  endtask

  logic [7:0] b;
  int         rises0;

  initial begin
    reset = 1'b1; uart_rxd = 8'h00; uart_rxd_strobe = 1'b0;
    uart_txd_ready = 1'b1; sd_idle = 1'b1; tb_ack = 1'b0;
    ack_delay = 4; mdl_cnt = 0; rd_count = 0; en_rises = 0; en_prev = 1'b0;
    mdl_ack = 1'b0; sd_rd_data = 16'h0000;
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_enable", sd_enable, 1'b0);
    check_eq("rst_we", sd_we, 1'b0);
    check_eq("rst_strobe", uart_txd_strobe, 1'b0);
    check_eq("rst_addr", sd_addr, 32'h0);
    check_eq("rst_mask", sd_wr_mask, 2'b00);
    check_eq("rst_wdata", sd_wr_data, 16'h0);
    check_eq("rst_txd", uart_txd, 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Three-byte write across lanes.
    send_frame(8'h57, 24'h000003, 32'h00000010);
    send_byte(8'hAA); wait_wr(1, 100);
    send_byte(8'hBB); wait_wr(2, 100);
    send_byte(8'hCC); wait_wr(3, 100);
    wait_tx(1, 100);
    get_tx(b); check_eq("wr_resp", b, 8'h77);
    check_wr("wr0", 32'h10, 2'b01, 16'h00AA);
    check_wr("wr1", 32'h11, 2'b10, 16'hBB00);
    check_wr("wr2", 32'h12, 2'b01, 16'h00CC);
    repeat (3) @(negedge clk);
    check_eq("wr_busy_done", busy, 1'b0);

    // Unaligned four-byte read: three word fetches.
    mem[8'h10 >> 1] = 16'hBBAA; mem[8'h12 >> 1] = 16'hDDCC; mem[8'h14 >> 1] = 16'hFFEE;
    rd_count = 0;
    send_frame(8'h52, 24'h000004, 32'h00000011);
    wait_tx(5, 300);
    get_tx(b); check_eq("rd_b0", b, 8'hBB);
    get_tx(b); check_eq("rd_b1", b, 8'hCC);
    get_tx(b); check_eq("rd_b2", b, 8'hDD);
    get_tx(b); check_eq("rd_b3", b, 8'hEE);
    get_tx(b); check_eq("rd_resp", b, 8'h72);
    check_eq("rd_count", rd_count, 3);

    // Unknown command and stray byte in WAIT.
    send_byte(8'h21); send_byte(8'h58);
    wait_tx(1, 50);
    get_tx(b); check_eq("unk_resp", b, 8'h3F);
    repeat (3) @(negedge clk);
    check_eq("unk_busy", busy, 1'b0);
    send_byte(8'h5A);
    wait_tx(1, 50);
    get_tx(b); check_eq("resync", b, 8'h21);
    check_eq("resync_busy", busy, 1'b0);

    // Overrun: second data byte arrives while the write is pending.
    ack_delay = 50;
    send_frame(8'h57, 24'h000001, 32'h00000020);
    send_byte(8'h11);
    repeat (5) @(negedge clk);
    send_byte(8'h22);
    wait_wr(1, 200);
    check_wr("ovr_wr", 32'h20, 2'b01, 16'h0011);
    wait_tx(1, 50);
    get_tx(b); check_eq("ovr_resp", b, 8'h25);
    check_eq("ovr_extra_wr", wr_addr_q.size(), 0);
    ack_delay = 4;

    // Version, then zero-length write.
    send_byte(8'h21); send_byte(8'h56);
    wait_tx(2, 50);
    get_tx(b); check_eq("ver_b0", b, 8'h32);
    get_tx(b); check_eq("ver_b1", b, 8'h02);
    rises0 = en_rises;
    send_frame(8'h57, 24'h000000, 32'h00000030);
    wait_tx(1, 50);
    get_tx(b); check_eq("len0_resp", b, 8'h77);
    repeat (5) @(negedge clk);
    check_eq("len0_no_req", en_rises, rises0);

    // Reset during an outstanding read, then a late ack.
    ack_delay = 30;
    send_frame(8'h52, 24'h000001, 32'h00000010);
    for (int i = 0; i < 100 && !sd_enable; i++) @(negedge clk);
    check_eq("rst_mid_enable", sd_enable, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tb_ack = 1'b1;
    @(negedge clk);
    tb_ack = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("rst_mid_en_off", sd_enable, 1'b0);
    check_eq("rst_mid_we", sd_we, 1'b0);
    check_eq("rst_mid_busy", busy, 1'b0);
    check_eq("rst_mid_addr", sd_addr, 32'h0);
    check_eq("rst_mid_txd", uart_txd, 8'h00);
    check_eq("rst_mid_no_tx", tx_q.size(), 0);
    ack_delay = 4;
    send_byte(8'h21); send_byte(8'h50);
    wait_tx(1, 50);
    get_tx(b); check_eq("ping_resp", b, 8'h70);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_mem_bridge.md
SERIAL_MEM_BRIDGE -- requirements
Module: serial_mem_bridge

Interface
REQ-001 Parameters SHALL be:
- ADDR_BITS, 32, memory byte address width (multiple of 8, 8..32).
- LEN_BITS, 24, transfer length width (multiple of 8, 8..32).
- DATA_BYTES, 2, memory word width in bytes (power of 2, 1..8).
- VERSION, 8'h32, byte returned by version command.
REQ-002 Ports SHALL be:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- uart_rxd  in  8  received byte.
- uart_rxd_strobe  in  1  uart_rxd valid for one cycle.
- uart_txd  out  8  byte to transmit.
- uart_txd_strobe  out  1  one-cycle transmit request.
- uart_txd_ready  in  1  transmitter can accept a byte.
- sd_addr  out  ADDR_BITS  byte address.
- sd_wr_data  out  8*DATA_BYTES  write word.
- sd_wr_mask  out  DATA_BYTES  byte-lane enables.
- sd_rd_data  in  8*DATA_BYTES  read word.
- sd_ack  in  1  request complete; sd_rd_data valid.
- sd_idle  in  1  controller accepts a request.
- sd_we  out  1  write, not read.
- sd_enable  out  1  request held until sd_ack.
- busy  out  1  command in progress.

Function
REQ-003 Frame: '!', command byte, then for R/W: LEN_BITS/8 length bytes, then ADDR_BITS/8 address bytes, both MSB first.
REQ-004 Commands: 'R' read, 'W' write, 'V' version, 'P' ping. Any other command byte SHALL transmit '?' and return to WAIT.
REQ-005 States: WAIT, CMD, LEN, ADDR, RD_REQ, RD_WAIT, RD_SEND, WR_DATA, WR_WAIT, RESP.
- Byte counters SHALL index the LEN and ADDR fields.
REQ-006 In WAIT, a non-'!' byte SHALL transmit '!' and remain in WAIT.
REQ-007 A length of 0 SHALL skip data and transmit only the completion byte.
REQ-008 Read byte lane SHALL be sd_addr[log2(DATA_BYTES)-1:0], with lane 0 = bits [7:0].
REQ-009 Read word caching:
- One SDRAM read SHALL be issued per word touched.
- Later bytes in the same word SHALL be served from a captured word register without a new request.
- A new request SHALL be issued when the address crosses a word boundary.
REQ-010 A read request SHALL assert sd_enable=1, sd_we=0 only when sd_idle=1 and no request is outstanding.
- On sd_ack, sd_enable SHALL deassert the next cycle and sd_rd_data SHALL be captured.
REQ-011 A read byte SHALL be strobed only when uart_txd_ready=1 and uart_txd_strobe was 0 the previous cycle.
- Each sent byte SHALL increment sd_addr and decrement the remaining length.
REQ-012 Write:
- Each received data byte SHALL be placed on its lane in sd_wr_data; other lanes zero.
- sd_wr_mask SHALL be one-hot on that lane.
- sd_enable=1 and sd_we=1 SHALL be asserted when sd_idle=1.
- On sd_ack: address +1, length -1, back to WR_DATA.
REQ-013 A data byte received while a write is outstanding SHALL be dropped, SHALL set a sticky overrun flag, and SHALL NOT corrupt the pending write.
REQ-014 Completion bytes are sent from RESP, waiting for uart_txd_ready:
- 'r' after read, 'w' after write, '%' instead if overrun was set.
- Then return to WAIT.
REQ-015 'V' SHALL transmit VERSION then DATA_BYTES as one byte. 'P' SHALL transmit 'p'.
REQ-016 Received bytes during RD_*, RESP and V/P output SHALL be ignored and set the overrun flag.
REQ-017 Address and length arithmetic SHALL wrap modulo 2^ADDR_BITS and 2^LEN_BITS.
REQ-018 busy SHALL be 1 in every state except WAIT.
REQ-019 uart_txd_strobe SHALL be at most one cycle per byte. uart_txd SHALL be stable while it is asserted.

Reset
REQ-020 Reset SHALL force:
- state WAIT.
- sd_enable=0, sd_we=0, uart_txd_strobe=0, busy=0, overrun=0.
- sd_addr=0, sd_wr_data=0, sd_wr_mask=0, uart_txd=0, length=0.
REQ-021 Reset mid-transfer SHALL abandon any outstanding SDRAM request without waiting for sd_ack. A following sd_ack SHALL be ignored.

Structure
REQ-022 Command characters, response characters and state encodings SHALL live in a shared package, serial_mem_pkg.
REQ-023 Transmit arbitration (ready/strobe pacing, one byte in flight) SHALL be a sub-module, uart_tx_pacer. All other logic SHALL be in one FSM.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- "!W" len 000003 addr 00000010, data AA BB CC; SDRAM model acks after 4 cycles -> three writes: mask 01 data 00AA @10, mask 10 data BB00 @11, mask 01 data 00CC @12; then 'w'.
- "!R" len 000004 addr 00000011, memory words @10=BBAA, @12=DDCC, @14=FFEE -> bytes BB CC DD EE; exactly 3 SDRAM reads; then 'r'.
- "!X" -> '?', busy falls. Byte 'Z' in WAIT -> '!'.
- Write with sd_ack held off 50 cycles while a second data byte arrives -> byte dropped, first write intact, completion '%'.
- "!V" with DATA_BYTES=2 -> 8'h32 then 8'h02. "!W" len 0 -> only 'w', no sd_enable.
- Reset asserted while sd_enable=1 in RD_WAIT, then a late sd_ack -> outputs at reset values, no UART byte sent, next "!P" -> 'p'.
